// File: rtl/eeg_rx_pkg.sv
`default_nettype none
// ============================================================================
// Module   : eeg_rx_pkg
// Purpose  : Shared constants for the EEG frame receiver: FSM state
//            encoding, default geometry and error-counter ceiling.
// Revision : 1.0 - initial release
// ============================================================================
package eeg_rx_pkg;

  localparam int WORD_W_DEFAULT          = 16;
  localparam int WORDS_PER_FRAME_DEFAULT = 4;

  localparam logic [7:0] ERR_CNT_MAX = 8'd255;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ARMED  = 2'd1;
  localparam logic [1:0] ST_SHIFT  = 2'd2;
  localparam logic [1:0] ST_PARITY = 2'd3;

  // Saturating increment of the 8-bit abort counter
  function automatic logic [7:0] err_cnt_inc(input logic [7:0] v);
    return (v == ERR_CNT_MAX) ? v : v + 8'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/eeg_frame_rx_rise_detect.sv
`default_nettype none
// ============================================================================
// Module   : rise_detect
// Purpose  : Registered rising-edge detector; emits a one-cycle pulse the
//            cycle after sig_in is first sampled high.
// Revision : 1.0 - initial release
// ============================================================================
module rise_detect (
  input  logic data_CLK,
  input  logic RST,
  input  logic sig_in,
  output logic rise
);

  logic prev_q, prev_d;
  logic rise_q, rise_d;

  // Next-state: remember last sample, flag a low-to-high transition
  always_comb begin
    prev_d = sig_in;
    rise_d = sig_in & ~prev_q;
  end

  // Edge-detect registers
  always_ff @(posedge data_CLK or posedge RST) begin
    if (RST) begin
      prev_q <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      prev_q <= prev_d;
      rise_q <= rise_d;
    end
  end

  assign rise = rise_q;

endmodule
`default_nettype wire

// File: rtl/eeg_frame_rx.sv
`default_nettype none
// ============================================================================
// Module   : eeg_frame_rx
// Purpose  : Serial EEG ADC frame receiver. Arms on a fifo_trig rise, starts
//            a frame on data_trig, deserialises WORDS_PER_FRAME words of
//            WORD_W bits (MSB first), passes raw bits to a 1-bit FIFO and
//            keeps frame / abort counters.
// Options  : FRAME_PARITY_EN - an even-parity bit follows every word.
// Revision : 1.0 - initial release
// ============================================================================
module eeg_frame_rx
  import eeg_rx_pkg::*;
#(
  parameter int WORD_W          = WORD_W_DEFAULT,
  parameter int WORDS_PER_FRAME = WORDS_PER_FRAME_DEFAULT
) (
  input  logic              data_CLK,
  input  logic              RST,
  input  logic              fifo_trig,
  input  logic              data_trig,
  input  logic              din,
  output logic [WORD_W-1:0] word_out,
  output logic              word_valid,
  output logic [1:0]        ch_idx,
  output logic              bit_out,
  output logic              bit_valid,
  output logic              frame_done,
  output logic              frame_err,
  output logic              par_err,
  output logic [15:0]       frame_cnt,
  output logic [7:0]        err_cnt,
  output logic [1:0]        state
);

  localparam int              BC_W      = $clog2(WORD_W);
  localparam logic [BC_W-1:0] LAST_BIT  = BC_W'(WORD_W - 1);
  localparam logic [1:0]      LAST_WORD = 2'(WORDS_PER_FRAME - 1);

  logic              arm_rise;

  logic [1:0]        state_q,      state_d;
  logic [WORD_W-1:0] shreg_q,      shreg_d;
  logic [BC_W-1:0]   bit_cnt_q,    bit_cnt_d;
  logic [1:0]        word_idx_q,   word_idx_d;
  logic [WORD_W-1:0] word_out_q,   word_out_d;
  logic              word_valid_q, word_valid_d;
  logic [1:0]        ch_idx_q,     ch_idx_d;
  logic              bit_out_q,    bit_out_d;
  logic              bit_valid_q,  bit_valid_d;
  logic              frame_done_q, frame_done_d;
  logic              frame_err_q,  frame_err_d;
  logic [15:0]       frame_cnt_q,  frame_cnt_d;
  logic [7:0]        err_cnt_q,    err_cnt_d;
  logic              word_fin;
`ifdef FRAME_PARITY_EN
  logic              par_err_q,    par_err_d;
`endif

  rise_detect u_rise_detect (
    .data_CLK (data_CLK),
    .RST      (RST),
    .sig_in   (fifo_trig),
    .rise     (arm_rise)
  );

  // Receiver FSM, deserialiser and counters; arming is held by state != IDLE
  always_comb begin
    state_d      = state_q;
    shreg_d      = shreg_q;
    bit_cnt_d    = bit_cnt_q;
    word_idx_d   = word_idx_q;
    word_out_d   = word_out_q;
    ch_idx_d     = ch_idx_q;
    bit_out_d    = bit_out_q;
    frame_cnt_d  = frame_cnt_q;
    err_cnt_d    = err_cnt_q;
    word_valid_d = 1'b0;
    bit_valid_d  = 1'b0;
    frame_done_d = 1'b0;
    frame_err_d  = 1'b0;
    word_fin     = 1'b0;
`ifdef FRAME_PARITY_EN
    par_err_d    = 1'b0;
`endif

    case (state_q)
      ST_IDLE: begin
        if (arm_rise) state_d = ST_ARMED;
      end
      ST_ARMED: begin
        if (data_trig) begin
          state_d    = ST_SHIFT;
          bit_cnt_d  = '0;
          word_idx_d = '0;
        end
      end
      default: begin
        if (data_trig) begin
          // A new frame strobe mid-frame aborts it and restarts reception
          state_d     = ST_SHIFT;
          shreg_d     = '0;
          bit_cnt_d   = '0;
          word_idx_d  = '0;
          frame_err_d = 1'b1;
          err_cnt_d   = err_cnt_inc(err_cnt_q);
        end else if (state_q == ST_SHIFT) begin
          shreg_d     = {shreg_q[WORD_W-2:0], din};
          bit_out_d   = din;
          bit_valid_d = 1'b1;
          if (bit_cnt_q == LAST_BIT) begin
            bit_cnt_d = '0;
`ifdef FRAME_PARITY_EN
            state_d   = ST_PARITY;
`else
            word_fin  = 1'b1;
`endif
          end else begin
            bit_cnt_d = bit_cnt_q + BC_W'(1);
          end
        end
`ifdef FRAME_PARITY_EN
        else begin
          // Even parity: word bits plus parity bit must XOR to zero
          word_fin  = 1'b1;
          par_err_d = ^{shreg_q, din};
        end
`endif
      end
    endcase

    if (word_fin) begin
      word_out_d   = shreg_d;
      ch_idx_d     = word_idx_q;
      word_valid_d = 1'b1;
      if (word_idx_q == LAST_WORD) begin
        frame_done_d = 1'b1;
        frame_cnt_d  = frame_cnt_q + 16'd1;
        word_idx_d   = '0;
        state_d      = ST_ARMED;
      end else begin
        word_idx_d = word_idx_q + 2'd1;
        state_d    = ST_SHIFT;
      end
    end
  end

  // State and output registers, cleared asynchronously by RST
  always_ff @(posedge data_CLK or posedge RST) begin
    if (RST) begin
      state_q      <= ST_IDLE;
      shreg_q      <= '0;
      bit_cnt_q    <= '0;
      word_idx_q   <= '0;
      word_out_q   <= '0;
      word_valid_q <= 1'b0;
      ch_idx_q     <= '0;
      bit_out_q    <= 1'b0;
      bit_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      frame_err_q  <= 1'b0;
      frame_cnt_q  <= '0;
      err_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      bit_cnt_q    <= bit_cnt_d;
      word_idx_q   <= word_idx_d;
      word_out_q   <= word_out_d;
      word_valid_q <= word_valid_d;
      ch_idx_q     <= ch_idx_d;
      bit_out_q    <= bit_out_d;
      bit_valid_q  <= bit_valid_d;
      frame_done_q <= frame_done_d;
      frame_err_q  <= frame_err_d;
      frame_cnt_q  <= frame_cnt_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

`ifdef FRAME_PARITY_EN
  // Parity-error flag register
  always_ff @(posedge data_CLK or posedge RST) begin
    if (RST) par_err_q <= 1'b0;
    else     par_err_q <= par_err_d;
  end

  assign par_err = par_err_q;
`else
  // Without parity the finished word is taken straight from the shift path,
  // so the oldest shift-register bit is never read back.
  logic unused_shreg_msb;
  assign unused_shreg_msb = shreg_q[WORD_W-1];
  assign par_err          = 1'b0;
`endif

  assign word_out   = word_out_q;
  assign word_valid = word_valid_q;
  assign ch_idx     = ch_idx_q;
  assign bit_out    = bit_out_q;
  assign bit_valid  = bit_valid_q;
  assign frame_done = frame_done_q;
  assign frame_err  = frame_err_q;
  assign frame_cnt  = frame_cnt_q;
  assign err_cnt    = err_cnt_q;
  assign state      = state_q;

endmodule
`default_nettype wire

// File: tb/tb_eeg_frame_rx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_eeg_frame_rx
// Purpose  : Self-checking bench for eeg_frame_rx against a transaction-level
//            model of frames, words, aborts and counters.
// Options  : FRAME_PARITY_EN - parity bit after every word.
// Revision : 1.0 - initial release
// ============================================================================
module tb_eeg_frame_rx;

  logic        data_CLK = 1'b0;
  logic        RST, fifo_trig, data_trig, din;
  logic [15:0] word_out;
  logic        word_valid;
  logic [1:0]  ch_idx;
  logic        bit_out, bit_valid, frame_done, frame_err, par_err;
  logic [15:0] frame_cnt;
  logic [7:0]  err_cnt;
  logic [1:0]  state;

  eeg_frame_rx #(.WORD_W(16), .WORDS_PER_FRAME(4)) dut (
    .data_CLK   (data_CLK),
    .RST        (RST),
    .fifo_trig  (fifo_trig),
    .data_trig  (data_trig),
    .din        (din),
    .word_out   (word_out),
    .word_valid (word_valid),
    .ch_idx     (ch_idx),
    .bit_out    (bit_out),
    .bit_valid  (bit_valid),
    .frame_done (frame_done),
    .frame_err  (frame_err),
    .par_err    (par_err),
    .frame_cnt  (frame_cnt),
    .err_cnt    (err_cnt),
    .state      (state)
  );

  always #5 data_CLK = ~data_CLK;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  int cyc = 0;
  always @(posedge data_CLK) cyc <= cyc + 1;

  typedef struct packed {
    logic [15:0] w;
    logic [1:0]  idx;
    logic        done;
    logic        perr;
  } wrec_t;

  wrec_t obs_w[$], exp_w[$];
  int    obs_wc[$], exp_wc[$];
  int    obs_fe[$], exp_fe[$];
  logic  obs_b[$], exp_b[$];
  int    pulse_viol = 0;
  logic  prev_wv = 0, prev_fd = 0, prev_fe = 0, prev_pe = 0;

  // Observe outputs mid-cycle
  always @(negedge data_CLK) begin
    if (word_valid) begin
      obs_w.push_back({word_out, ch_idx, frame_done, par_err});
      obs_wc.push_back(cyc);
    end
    if (frame_err) obs_fe.push_back(cyc);
    if (bit_valid) obs_b.push_back(bit_out);
    if ((word_valid && prev_wv) || (frame_done && prev_fd) ||
        (frame_err && prev_fe) || (par_err && prev_pe)) pulse_viol++;
    if ((frame_done || par_err) && !word_valid) pulse_viol++;
    prev_wv = word_valid; prev_fd = frame_done; prev_fe = frame_err; prev_pe = par_err;
  end

  // ---------------- reference model ----------------
  bit          armed = 0, in_frame = 0, await_par = 0, ft_rand = 0;
  int          nbits = 0, widx = 0, exp_frames = 0, exp_err = 0;
  logic [15:0] cur = '0;

  task automatic emit(input logic [15:0] w, input logic pe);
    exp_w.push_back({w, 2'(widx), (widx == 3), pe});
    exp_wc.push_back(cyc + 1);
    if (widx == 3) begin
      exp_frames = (exp_frames + 1) % 65536;
      in_frame   = 0;
      widx       = 0;
    end else begin
      widx++;
    end
  endtask

  task automatic tick(input logic trig, input logic b);
    @(negedge data_CLK);
    data_trig = trig;
    din       = b;
    fifo_trig = (ft_rand && armed) ? 1'($urandom) : 1'b0;
    if (armed) begin
      if (trig) begin
        if (in_frame) begin
          exp_err = (exp_err < 255) ? exp_err + 1 : 255;
          exp_fe.push_back(cyc + 1);
        end
        in_frame = 1; widx = 0; nbits = 0; await_par = 0;
      end else if (in_frame) begin
        if (await_par) begin
          await_par = 0;
          emit(cur, ^cur ^ b);
        end else begin
          cur = {cur[14:0], b};
          exp_b.push_back(b);
          nbits++;
          if (nbits == 16) begin
            nbits = 0;
`ifdef FRAME_PARITY_EN
            await_par = 1;
`else
            emit(cur, 1'b0);
`endif
          end
        end
      end
    end
  endtask

  task automatic send_word(input logic [15:0] w);
    for (int i = 15; i >= 0; i--) tick(1'b0, w[i]);
`ifdef FRAME_PARITY_EN
    tick(1'b0, 1'($urandom));
`endif
  endtask

  task automatic send_frame(input logic [63:0] f);
    tick(1'b1, 1'($urandom));
    for (int i = 0; i < 4; i++) send_word(f[63-16*i -: 16]);
  endtask

  task automatic arm();
    int k;
    k = 0;
    @(negedge data_CLK);
    fifo_trig = 1'b1;
    data_trig = 1'b0;
    while (state !== 2'd1 && k < 4) begin
      @(posedge data_CLK); #1;
      k++;
    end
    chk("arm_within_2", {63'd0, (state === 2'd1 && k <= 2)}, 64'd1);
    armed = 1;
    @(negedge data_CLK);
    fifo_trig = 1'b0;
  endtask

  task automatic compare_all(input string ph);
    int nbad;
    repeat (2) @(posedge data_CLK);
    #1;
    chk({ph, ".n_words"}, obs_w.size(), exp_w.size());
    for (int i = 0; i < exp_w.size() && i < obs_w.size(); i++) begin
      chk({ph, ".word"}, obs_w[i], exp_w[i]);
      chk({ph, ".word_cyc"}, obs_wc[i], exp_wc[i]);
    end
    chk({ph, ".n_frame_err"}, obs_fe.size(), exp_fe.size());
    for (int i = 0; i < exp_fe.size() && i < obs_fe.size(); i++)
      chk({ph, ".frame_err_cyc"}, obs_fe[i], exp_fe[i]);
    chk({ph, ".n_bits"}, obs_b.size(), exp_b.size());
    nbad = 0;
    for (int i = 0; i < exp_b.size() && i < obs_b.size(); i++)
      if (obs_b[i] !== exp_b[i]) nbad++;
    chk({ph, ".bit_stream"}, nbad, 0);
    chk({ph, ".frame_cnt"}, frame_cnt, exp_frames);
    chk({ph, ".err_cnt"}, err_cnt, exp_err);
    chk({ph, ".pulse_width"}, pulse_viol, 0);
    obs_w.delete(); exp_w.delete(); obs_wc.delete(); exp_wc.delete();
    obs_fe.delete(); exp_fe.delete(); obs_b.delete(); exp_b.delete();
  endtask

  task automatic finish_frame();
    int guard;
    guard = 0;
    while (in_frame && guard < 200) begin
      tick(1'b0, 1'($urandom));
      guard++;
    end
    chk("finish_frame_bound", {63'd0, in_frame}, 64'd0);
  endtask

  function automatic logic [63:0] outs_packed();
    return {8'd0, word_out, word_valid, ch_idx, bit_out, bit_valid, frame_done,
            frame_err, par_err, frame_cnt, err_cnt, state};
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    RST = 1'b1; fifo_trig = 1'b0; data_trig = 1'b0; din = 1'b0;
    repeat (3) @(posedge data_CLK);
    #1;
    chk("reset_outs_zero", outs_packed(), 64'd0);
    @(negedge data_CLK);
    RST = 1'b0;
    repeat (4) @(posedge data_CLK);
    #1;
    chk("pre_arm_outs_zero", outs_packed(), 64'd0);

    arm();

    // Directed frame
    send_frame({16'hA5A5, 16'h1234, 16'hFFFF, 16'h0001});
    compare_all("directed");
    chk("state_after_frame", state, 2'd1);

    // Abort after 20 bits, then the restarted frame completes
    tick(1'b1, 1'b0);
    for (int i = 0; i < 20; i++) tick(1'b0, 1'($urandom));
    tick(1'b1, 1'b0);
    @(posedge data_CLK); #1;
    chk("state_after_abort", state, 2'd2);
    for (int i = 0; i < 4; i++) send_word(16'($urandom));
    compare_all("abort20");

    // Strobe lands on a word's final bit slot: word discarded
    tick(1'b1, 1'b0);
    for (int i = 0; i < 31; i++) tick(1'b0, 1'($urandom));
    tick(1'b1, 1'b0);
    finish_frame();
    compare_all("abort_last_bit");

`ifdef FRAME_PARITY_EN
    // Parity: 0x0003 with parity 1 flags error, with parity 0 does not
    tick(1'b1, 1'b0);
    for (int i = 15; i >= 0; i--) tick(1'b0, (i < 2));
    tick(1'b0, 1'b1);
    for (int i = 15; i >= 0; i--) tick(1'b0, (i < 2));
    tick(1'b0, 1'b0);
    finish_frame();
    compare_all("parity");
`endif

    // Randomised frames, aborts and spurious fifo_trig activity
    ft_rand = 1;
    for (int n = 0; n < 25; n++) begin
      if (!in_frame) repeat ($urandom_range(0, 3)) tick(1'b0, 1'($urandom));
      tick(1'b1, 1'($urandom));
      if ($urandom_range(0, 9) < 7) begin
        for (int i = 0; i < 4; i++) send_word(16'($urandom));
      end else begin
        repeat ($urandom_range(1, 70)) tick(1'b0, 1'($urandom));
      end
    end
    finish_frame();
    ft_rand = 0;
    tick(1'b0, 1'b0);
    compare_all("random");

    // frame_cnt wrap from 0xFFFF
    @(negedge data_CLK);
    force dut.frame_cnt_q = 16'hFFFF;
    @(posedge data_CLK); #1;
    release dut.frame_cnt_q;
    exp_frames = 65535;
    @(negedge data_CLK);
    chk("frame_cnt_preload", frame_cnt, 16'hFFFF);
    send_frame({4{16'($urandom)}});
    compare_all("wrap");

    // 256 aborts saturate err_cnt
    tick(1'b1, 1'b0);
    for (int n = 0; n < 256; n++) begin
      repeat ($urandom_range(1, 3)) tick(1'b0, 1'($urandom));
      tick(1'b1, 1'b0);
    end
    finish_frame();
    compare_all("saturate");
    chk("err_cnt_sat", err_cnt, 8'd255);

    // Asynchronous reset in the middle of word 2
    tick(1'b1, 1'b0);
    send_word(16'hBEEF);
    send_word(16'h7E57);
    for (int i = 0; i < 10; i++) tick(1'b0, 1'($urandom));
    @(negedge data_CLK);
    data_trig = 1'b0;
    #2;
    RST = 1'b1;
    #1;
    chk("rst_state_idle", state, 2'd0);
    chk("rst_outs_zero", outs_packed(), 64'd0);
    armed = 0; in_frame = 0; await_par = 0; nbits = 0; widx = 0;
    exp_frames = 0; exp_err = 0;
    repeat (2) @(posedge data_CLK);
    @(negedge data_CLK);
    RST = 1'b0;
    compare_all("mid_reset");

    // Recovery after reset
    arm();
    send_frame({16'h0F0F, 16'hF0F0, 16'h8001, 16'h7FFE});
    compare_all("recover");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
